// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_pkg
// Purpose  : Shared mode encodings and seven-segment table for hex_display_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_UP     = 2'b10;
    localparam logic [1:0] MODE_DOWN   = 2'b11;

    localparam logic [7:0] SEG_BLANK   = 8'hFF;

    // Active-low g..a patterns; entry n sits at SEG_TABLE[n].
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage : hex_display_pkg
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg
// Purpose  : Nibble plus blank/dp controls to one active-low segment byte.
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {~dp_i, blank_i ? 7'h7F : SEG_TABLE[nibble_i]};

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_ctrl
// Purpose  : Multi-digit hex display driver with static/blink/count modes.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 25_000_000
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] data_in_i,
    input  logic [1:0]              mode_i,
    input  logic                    blank_lz_i,
    input  logic [NUM_DIGITS-1:0]   dp_mask_i,
    output logic [8*NUM_DIGITS-1:0] hex_out_o,
    output logic                    carry_o
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]   prescaler_q, prescaler_d;
    logic [VW-1:0]   value_q, value_d;
    logic            phase_q, phase_d;
    logic            loaded_q, loaded_d;
    logic            carry_q, carry_d;
    logic [8*NUM_DIGITS-1:0] hex_q, hex_d;

    logic                    tick;
    logic [NUM_DIGITS:0]     zero_above;
    logic [NUM_DIGITS-1:0]   blank;
    logic [8*NUM_DIGITS-1:0] seg_flat;

    assign tick = (prescaler_q == PW'(TICK_DIV - 1));

    always_comb begin
        value_d     = value_q;
        prescaler_d = tick ? '0 : prescaler_q + PW'(1);
        phase_d     = (mode_i == MODE_BLINK) ? (phase_q ^ tick) : 1'b0;
        loaded_d    = loaded_q;
        carry_d     = 1'b0;
        if (load_i) begin
            // A coincident tick is dropped: no step, no phase toggle.
            value_d     = data_in_i;
            prescaler_d = '0;
            phase_d     = 1'b0;
            loaded_d    = 1'b1;
        end else if (tick && loaded_q) begin
            if (mode_i == MODE_UP) begin
                value_d = value_q + VW'(1);
                carry_d = &value_q;
            end else if (mode_i == MODE_DOWN) begin
                value_d = value_q - VW'(1);
                carry_d = (value_q == '0);
            end
        end
    end

    // zero_above[i]: digit i and every digit left of it are zero.
    always_comb begin
        zero_above[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (value_q[4*i +: 4] == 4'h0);
        end
        blank = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            blank[i] = blank_lz_i && zero_above[i];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        hex_to_seg u_hex_to_seg (
            .nibble_i (value_q[4*g +: 4]),
            .blank_i  (blank[g]),
            .dp_i     (dp_mask_i[g]),
            .seg_o    (seg_flat[8*g +: 8])
        );
    end

    // Display stays dark until the first value is loaded.
    always_comb begin
        hex_d = seg_flat;
        if (!loaded_q || (phase_q && (mode_i == MODE_BLINK))) begin
            hex_d = {NUM_DIGITS{SEG_BLANK}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prescaler_q <= '0;
            value_q     <= '0;
            phase_q     <= 1'b0;
            loaded_q    <= 1'b0;
            carry_q     <= 1'b0;
            hex_q       <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            prescaler_q <= prescaler_d;
            value_q     <= value_d;
            phase_q     <= phase_d;
            loaded_q    <= loaded_d;
            carry_q     <= carry_d;
            hex_q       <= hex_d;
        end
    end

    assign hex_out_o = hex_q;
    assign carry_o   = carry_q;

endmodule : hex_display_ctrl
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_ctrl
// Purpose  : Directed self-checking bench for hex_display_ctrl (4 digits, tick=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data;
    logic [1:0]  mode;
    logic        blz;
    logic [3:0]  dpm;
    logic [31:0] hex_out;
    logic        carry;

    int n_pass  = 0;
    int n_total = 0;

    hex_display_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .load_i     (load),
        .data_in_i  (data),
        .mode_i     (mode),
        .blank_lz_i (blz),
        .dp_mask_i  (dpm),
        .hex_out_o  (hex_out),
        .carry_o    (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; capture happens at the next edge.
    task automatic do_load(input logic [15:0] d);
        load = 1'b1;
        data = d;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        data  = 16'h0;
        mode  = 2'b00;
        blz   = 1'b0;
        dpm   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (hex_out !== 32'hFFFF_FFFF) $display("FAIL reset_hex actual=%h required=%h", hex_out, 32'hFFFF_FFFF);
        else n_pass++;
        n_total++;
        if (carry !== 1'b0) $display("FAIL reset_carry actual=%b required=0", carry);
        else n_pass++;
        rst_n = 1'b1;
        repeat (10) step();
        n_total++;
        if (hex_out !== 32'hFFFF_FFFF) $display("FAIL post_release_hex actual=%h required=%h", hex_out, 32'hFFFF_FFFF);
        else n_pass++;
        n_total++;
        if (carry !== 1'b0) $display("FAIL post_release_carry actual=%b required=0", carry);
        else n_pass++;
    endtask

    task automatic test_static();
        mode = 2'b00; blz = 1'b0; dpm = 4'h0;
        do_load(16'h12AF);
        step();
        n_total++;
        if (hex_out !== 32'hF9A4_888E) $display("FAIL static_12AF actual=%h required=%h", hex_out, 32'hF9A4_888E);
        else n_pass++;
    endtask

    task automatic test_blank_lz();
        mode = 2'b00; blz = 1'b1; dpm = 4'h0;
        do_load(16'h0030);
        step();
        n_total++;
        if (hex_out !== 32'hFFFF_B0C0) $display("FAIL lz_0030 actual=%h required=%h", hex_out, 32'hFFFF_B0C0);
        else n_pass++;
        dpm = 4'b0100;
        do_load(16'h0000);
        step();
        n_total++;
        if (hex_out !== 32'hFF7F_FFC0) $display("FAIL lz_0000_dp actual=%h required=%h", hex_out, 32'hFF7F_FFC0);
        else n_pass++;
    endtask

    task automatic test_count_up();
        int pulses;
        int pulse_at;
        pulses = 0; pulse_at = -1;
        mode = 2'b10; blz = 1'b0; dpm = 4'h0;
        do_load(16'hFFFE);
        for (int c = 1; c <= 9; c++) begin
            step();
            if (carry === 1'b1) begin
                pulses++;
                pulse_at = c;
            end
            if (c == 4) begin
                n_total++;
                if (hex_out !== 32'h8E8E_8E86) $display("FAIL up_hold_FFFE actual=%h required=%h", hex_out, 32'h8E8E_8E86);
                else n_pass++;
            end
            if (c == 5) begin
                n_total++;
                if (hex_out !== 32'h8E8E_8E8E) $display("FAIL up_FFFF actual=%h required=%h", hex_out, 32'h8E8E_8E8E);
                else n_pass++;
            end
            if (c == 9) begin
                n_total++;
                if (hex_out !== 32'hC0C0_C0C0) $display("FAIL up_wrap_0000 actual=%h required=%h", hex_out, 32'hC0C0_C0C0);
                else n_pass++;
            end
        end
        n_total++;
        if (pulses != 1 || pulse_at != 8)
            $display("FAIL up_carry_pulse actual=count %0d at cycle %0d required=count 1 at cycle 8", pulses, pulse_at);
        else n_pass++;
    endtask

    task automatic test_count_down();
        mode = 2'b11; blz = 1'b0; dpm = 4'h0;
        do_load(16'h0000);
        repeat (3) step();
        n_total++;
        if (carry !== 1'b0) $display("FAIL down_carry_early actual=%b required=0", carry);
        else n_pass++;
        step();
        n_total++;
        if (carry !== 1'b1) $display("FAIL down_carry_wrap actual=%b required=1", carry);
        else n_pass++;
        step();
        n_total++;
        if (carry !== 1'b0 || hex_out !== 32'h8E8E_8E8E)
            $display("FAIL down_FFFF actual=%h/%b required=%h/0", hex_out, carry, 32'h8E8E_8E8E);
        else n_pass++;
    endtask

    task automatic test_blink();
        mode = 2'b01; blz = 1'b1; dpm = 4'b0001;
        do_load(16'h0005);
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1 || c == 4 || c == 9) begin
                n_total++;
                if (hex_out !== 32'hFFFF_FF12) $display("FAIL blink_on_c%0d actual=%h required=%h", c, hex_out, 32'hFFFF_FF12);
                else n_pass++;
            end
            if (c == 5 || c == 8) begin
                n_total++;
                if (hex_out !== 32'hFFFF_FFFF) $display("FAIL blink_off_c%0d actual=%h required=%h", c, hex_out, 32'hFFFF_FFFF);
                else n_pass++;
            end
        end
    endtask

    task automatic test_load_on_tick();
        mode = 2'b10; blz = 1'b0; dpm = 4'h0;
        do_load(16'h1000);
        repeat (3) step();
        do_load(16'h1234);
        step();
        n_total++;
        if (hex_out !== 32'hF9A4_B099) $display("FAIL collide_1234 actual=%h required=%h", hex_out, 32'hF9A4_B099);
        else n_pass++;
        repeat (3) step();
        n_total++;
        if (hex_out !== 32'hF9A4_B099) $display("FAIL collide_hold actual=%h required=%h", hex_out, 32'hF9A4_B099);
        else n_pass++;
        step();
        n_total++;
        if (hex_out !== 32'hF9A4_B092) $display("FAIL collide_1235 actual=%h required=%h", hex_out, 32'hF9A4_B092);
        else n_pass++;
    endtask

    task automatic test_reset_mid_count();
        mode = 2'b10; blz = 1'b0; dpm = 4'hF;
        do_load(16'hFFFF);
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (hex_out !== 32'hFFFF_FFFF) $display("FAIL midrst_hex actual=%h required=%h", hex_out, 32'hFFFF_FFFF);
        else n_pass++;
        n_total++;
        if (carry !== 1'b0) $display("FAIL midrst_carry actual=%b required=0", carry);
        else n_pass++;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        n_total++;
        if (hex_out !== 32'hFFFF_FFFF) $display("FAIL midrst_release actual=%h required=%h", hex_out, 32'hFFFF_FFFF);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_static();
        test_blank_lz();
        test_count_up();
        test_count_down();
        test_blink();
        test_load_on_tick();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hex_display_ctrl
`default_nettype wire

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised multi-digit hexadecimal display controller that drives NUM_DIGITS active-low seven-segment displays (with decimal point) from a loaded value. It adds on-chip sequencing: static, blinking, and free-running up/down count modes, with leading-zero blanking and per-digit decimal points. It sits between switch/bus logic and the board HEX pins, replacing per-display combinational decoders.

## Interface
- NUM_DIGITS, 4: number of digits driven, 1..8.
- TICK_DIV, 25_000_000: clock cycles per tick, ≥2; sets blink half-period and count step rate.
- CLK  in  1  system clock; all state updates on its rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- LOAD  in  1  single-cycle strobe: capture DATA_IN into the value register.
- DATA_IN  in  4*NUM_DIGITS  value to load; nibble i drives digit i (digit 0 rightmost).
- MODE  in  2  00 static, 01 blink, 10 count up, 11 count down; sampled every cycle.
- BLANK_LZ  in  1  1 = blank leading zero digits.
- DP_MASK  in  NUM_DIGITS  bit i = 1 lights the decimal point of digit i.
- HEX_OUT  out  8*NUM_DIGITS  byte i drives digit i; bit 7 = dp, bits 6:0 = g..a, active-low.
- CARRY  out  1  one-cycle pulse on count wrap-around.

## Operation
- Reset: value = 0, prescaler = 0, blink phase = 0, HEX_OUT = all ones (every digit dark, dp off), CARRY = 0.
- Prescaler counts 0..TICK_DIV-1 and wraps; tick = prescaler at TICK_DIV-1. It runs in all modes.
- LOAD: value <= DATA_IN, prescaler <= 0, blink phase <= 0. LOAD takes priority over a coincident tick; that tick is discarded (no count step, no phase toggle).
- Static (00): value held; digits always shown.
- Blink (01): phase toggles on each tick; phase 1 forces every byte of HEX_OUT to 8'hFF (dp included). Phase is cleared whenever MODE != 01.
- Count up (10) / down (11): on tick, value <= value ± 1 modulo 2^(4*NUM_DIGITS). Wrap from all-F to 0 (up) or 0 to all-F (down) asserts CARRY for exactly that one cycle.
- Decode per nibble, bits 6:0 active-low: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex).
- Leading-zero blanking (BLANK_LZ=1): digit i is blanked (bits 6:0 = 7F) if it and all higher digits are zero, for i ≥ 1; digit 0 is never blanked. The dp still follows DP_MASK on such digits.
- dp: bit 7 = ~DP_MASK[i], except during blink phase 1.
- MODE, BLANK_LZ and DP_MASK changes take effect on the next HEX_OUT update; no capture is required.

## Timing
- LOAD high before edge k: value valid after edge k. HEX_OUT reflects it after edge k+1 (one registered output stage).
- A tick at edge k updates value and CARRY at edge k. HEX_OUT follows at edge k+1.
- Blink period = 2*TICK_DIV cycles. Count rate = one step per TICK_DIV cycles after the last LOAD.
- RST_N low forces all outputs to reset values immediately, including mid-count or mid-blink. The first tick after release comes TICK_DIV cycles after the first active edge.

## Structure
- Package hex_display_pkg holds:
  - MODE_STATIC/MODE_BLINK/MODE_UP/MODE_DOWN constants.
  - SEG_BLANK = 8'hFF.
  - The nibble-to-segment table constant.
- Sub-module hex_to_seg: combinational nibble, blank and dp to 8-bit segment byte. It is instantiated NUM_DIGITS times by generate.
- The top level holds the prescaler, value register, blink phase, leading-zero chain and output register.

## Test plan
Use NUM_DIGITS=4, TICK_DIV=4 unless noted.
- Reset: hold RST_N low → HEX_OUT = FFFF_FFFF, CARRY = 0. Release → outputs remain unchanged until a LOAD.
- Static load: LOAD with DATA_IN = 12AF, DP_MASK = 0, BLANK_LZ = 0 → one cycle after capture, HEX_OUT = F9_A4_88_8E.
- Leading-zero blanking, BLANK_LZ = 1:
  - LOAD 0030 → HEX_OUT = FF_FF_B0_C0.
  - LOAD 0000 with DP_MASK = 0100 → HEX_OUT = FF_7F_FF_C0.
- Count and wrap: LOAD FFFE, MODE = 10 → value FFFF after 4 cycles, 0000 after 8 cycles. CARRY is high for exactly one cycle at that edge. MODE = 11 from 0000 → FFFF with a CARRY pulse.
- Blink: LOAD 0005, MODE = 01, DP_MASK = 0001 → HEX_OUT alternates every 4 cycles between FF_FF_FF_12 (BLANK_LZ = 1) and FF_FF_FF_FF.
- Collisions:
  - LOAD 1234 on a tick edge in count-up → value 1234, no increment; the next step lands 4 cycles later at 1235.
  - Assert RST_N low mid-count → HEX_OUT = all FF in the same cycle.
